// File: rtl/stage_cfg_pkg.sv
// Shared types and constants for the reconfiguration scheduler.
package stage_cfg_pkg;

    localparam int CFG_DATA_W = 512;
    localparam int CFG_USER_W = 128;
    localparam int CFG_KEEP_W = CFG_DATA_W / 8;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SEND,
        SETTLE
    } sched_state_e;

    typedef struct packed {
        logic [CFG_DATA_W-1:0] tdata;
        logic [CFG_USER_W-1:0] tuser;
        logic [CFG_KEEP_W-1:0] tkeep;
        logic                  tlast;
    } ctrl_beat_t;

endpackage

// File: rtl/ctrl_beat_fifo.sv
// Synchronous show-ahead FIFO for control beats with a free-space count.
module ctrl_beat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && (count != FULL);
    assign do_rd   = rd_en && (count != '0);
    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign free    = FULL - count;

    // Beat storage.
    // NOTE: the array has no reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: all state updates use <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stage_cfg_sched.sv
// Holds control packets, quiesces the PHV path, then streams them to the stage chain.
module stage_cfg_sched
    import stage_cfg_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = CFG_DATA_W,
    parameter int C_S_AXIS_TUSER_WIDTH = CFG_USER_W,
    parameter int PHV_LEN              = 48*8+32*8+16*8+5*20+256,
    parameter int CNT_W                = 6,
    parameter int FIFO_DEPTH           = 16,
    parameter int MAX_PKT_BEATS        = 4,
    parameter int DRAIN_TIMEOUT        = 1024,
    parameter int SETTLE_CYC           = 8
) (
    input  logic                              axis_clk,
    input  logic                              areset,
    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic                              phv_in_valid,
    output logic                              ready_out,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_out_valid,
    input  logic                              pipe_ready_in,
    input  logic                              phv_retire,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,
    output logic                              drain_err,
    output logic [DROP_CNT_W-1:0]             drop_cnt
);

    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W  = $clog2(MAX_PKT_BEATS + 1);
    localparam int TMR_W  = $clog2(((DRAIN_TIMEOUT > SETTLE_CYC) ? DRAIN_TIMEOUT : SETTLE_CYC) + 1);

    localparam logic [CNT_W-1:0]  INFLIGHT_MAX = '1;
    localparam logic [IDX_W-1:0]  MAX_IDX      = IDX_W'(MAX_PKT_BEATS);
    localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(MAX_PKT_BEATS - 1);
    localparam logic [FREE_W-1:0] PKT_SPACE    = FREE_W'(MAX_PKT_BEATS);
    localparam logic [TMR_W-1:0]  DRAIN_LAST   = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  SETTLE_LAST  = TMR_W'(SETTLE_CYC);

    sched_state_e      state;
    sched_state_e      state_n;
    logic              gate_open;
    logic [CNT_W-1:0]  inflight;
    logic [TMR_W-1:0]  timer;
    logic [FREE_W-1:0] pkt_cnt;
    logic              in_pkt;
    logic              pkt_keep;
    logic [IDX_W-1:0]  beat_idx;
    logic [IDX_W-1:0]  idx_now;
    logic              keep_now;
    logic [FREE_W-1:0] fifo_free;
    logic              fifo_empty;
    ctrl_beat_t        wr_beat;
    ctrl_beat_t        rd_beat;
    logic              wr_en;
    logic              rd_en;
    logic              pkt_wr;
    logic              pkt_rd;
    logic              phv_fire;
    logic              underflow;
    logic              overflow;
    logic              drain_timeout;

    // The gate is purely combinational so PHVs see no added latency.
    assign phv_out       = phv_in;
    assign phv_out_valid = phv_in_valid & gate_open;
    assign ready_out     = pipe_ready_in & gate_open;
    assign phv_fire      = phv_out_valid & pipe_ready_in;
    assign underflow     = phv_retire & ~phv_fire & (inflight == '0);
    assign overflow      = phv_fire & ~phv_retire & (inflight == INFLIGHT_MAX);

    // Admission is decided at a packet's first beat; later beats follow that decision.
    assign keep_now = in_pkt ? pkt_keep : (fifo_free >= PKT_SPACE);
    assign idx_now  = in_pkt ? beat_idx : '0;
    assign wr_en    = c_s_axis_tvalid & keep_now & (idx_now < MAX_IDX);
    assign wr_beat  = {c_s_axis_tdata, c_s_axis_tuser, c_s_axis_tkeep,
                       c_s_axis_tlast | (idx_now == LAST_IDX)};
    assign pkt_wr   = wr_en & wr_beat.tlast;
    assign pkt_rd   = rd_en & rd_beat.tlast;

    ctrl_beat_fifo #(
        .WIDTH ($bits(ctrl_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (axis_clk),
        .rst     (areset),
        .wr_en   (wr_en),
        .wr_data (wr_beat),
        .rd_en   (rd_en),
        .rd_data (rd_beat),
        .empty   (fifo_empty),
        .free    (fifo_free)
    );

    // Track PHVs between stage 0 entry and last-stage retirement.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            inflight <= '0;
        end else begin
            case ({phv_fire, phv_retire})
                2'b10:   if (!overflow)  inflight <= inflight + CNT_W'(1);
                2'b01:   if (!underflow) inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Ingress packet framing, truncation and drop counting.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            in_pkt   <= 1'b0;
            pkt_keep <= 1'b0;
            beat_idx <= '0;
            drop_cnt <= '0;
        end else if (c_s_axis_tvalid) begin
            in_pkt   <= ~c_s_axis_tlast;
            pkt_keep <= keep_now;
            beat_idx <= wr_en ? idx_now + IDX_W'(1) : idx_now;
            if (!in_pkt && !keep_now && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    // Count complete packets held in the buffer.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            pkt_cnt <= '0;
        end else begin
            case ({pkt_wr, pkt_rd})
                2'b10:   pkt_cnt <= pkt_cnt + FREE_W'(1);
                2'b01:   pkt_cnt <= pkt_cnt - FREE_W'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // Next-state and pop decisions.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_n       = state;
        rd_en         = 1'b0;
        drain_timeout = 1'b0;
        unique case (state)
            IDLE: begin
                if (pkt_cnt != '0) state_n = DRAIN;
            end
            DRAIN: begin
                if (inflight == '0) begin
                    state_n = SEND;
                end else if (timer == DRAIN_LAST) begin
                    drain_timeout = 1'b1;
                    state_n       = SEND;
                end
            end
            SEND: begin
                rd_en = ~fifo_empty;
                if (!fifo_empty && rd_beat.tlast) state_n = SETTLE;
            end
            SETTLE: begin
                if (timer == SETTLE_LAST) state_n = (pkt_cnt != '0) ? DRAIN : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, gate, phase timer and sticky error registers.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            gate_open <= 1'b1;
            timer     <= '0;
            drain_err <= 1'b0;
        end else begin
            state     <= state_n;
            gate_open <= (state_n == IDLE);
            timer     <= (state_n != state || state == IDLE) ? '0 : timer + TMR_W'(1);
            drain_err <= drain_err | drain_timeout | underflow | overflow;
        end
    end

    // Registered control output; fields are zeroed whenever no beat is popped.
    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end else if (rd_en) begin
            c_m_axis_tdata  <= rd_beat.tdata;
            c_m_axis_tuser  <= rd_beat.tuser;
            c_m_axis_tkeep  <= rd_beat.tkeep;
            c_m_axis_tvalid <= 1'b1;
            c_m_axis_tlast  <= rd_beat.tlast;
        end else begin
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_cfg_sched.sv
// Self-checking bench for stage_cfg_sched: transaction-level model plus directed timing checks.
`timescale 1ns/1ps
module tb_stage_cfg_sched;
    import stage_cfg_pkg::*;

    localparam int PHV_W = 32;
    localparam int DW    = CFG_DATA_W;
    localparam int UW    = CFG_USER_W;
    localparam int KW    = CFG_KEEP_W;
    localparam int DEPTH = 16;
    localparam int MAXB  = 4;
    localparam int DTO   = 16;

    logic             axis_clk = 1'b0;
    logic             areset;
    logic [PHV_W-1:0] phv_in, phv_out;
    logic             phv_in_valid, ready_out, phv_out_valid, pipe_ready_in, phv_retire;
    logic [DW-1:0]    s_tdata, m_tdata;
    logic [UW-1:0]    s_tuser, m_tuser;
    logic [KW-1:0]    s_tkeep, m_tkeep;
    logic             s_tvalid, s_tlast, m_tvalid, m_tlast;
    logic             drain_err;
    logic [15:0]      drop_cnt;

    stage_cfg_sched #(
        .PHV_LEN       (PHV_W),
        .FIFO_DEPTH    (DEPTH),
        .MAX_PKT_BEATS (MAXB),
        .DRAIN_TIMEOUT (DTO),
        .SETTLE_CYC    (8)
    ) dut (
        .axis_clk        (axis_clk),
        .areset          (areset),
        .phv_in          (phv_in),
        .phv_in_valid    (phv_in_valid),
        .ready_out       (ready_out),
        .phv_out         (phv_out),
        .phv_out_valid   (phv_out_valid),
        .pipe_ready_in   (pipe_ready_in),
        .phv_retire      (phv_retire),
        .c_s_axis_tdata  (s_tdata),
        .c_s_axis_tuser  (s_tuser),
        .c_s_axis_tkeep  (s_tkeep),
        .c_s_axis_tvalid (s_tvalid),
        .c_s_axis_tlast  (s_tlast),
        .c_m_axis_tdata  (m_tdata),
        .c_m_axis_tuser  (m_tuser),
        .c_m_axis_tkeep  (m_tkeep),
        .c_m_axis_tvalid (m_tvalid),
        .c_m_axis_tlast  (m_tlast),
        .drain_err       (drain_err),
        .drop_cnt        (drop_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    ctrl_beat_t exp_q[$];
    ctrl_beat_t got_b, exp_b, new_b;
    int m_stored, m_emitted, m_inflight, m_drop, m_idx;
    bit m_err, m_in_pkt, m_keep, prev_err, hs;

    initial begin
        m_stored = 0; m_emitted = 0; m_inflight = 0; m_drop = 0; m_idx = 0;
        m_err = 0; m_in_pkt = 0; m_keep = 0; prev_err = 0;
    end

    // One compare process, sampling on the falling edge.
    always @(negedge axis_clk) begin
        if (areset) begin
            exp_q.delete();
            m_stored = 0; m_emitted = 0; m_inflight = 0; m_drop = 0; m_idx = 0;
            m_err = 0; m_in_pkt = 0; m_keep = 0; prev_err = 0;
        end else begin
            check("phv_passthru", phv_out, phv_in);
            if (pipe_ready_in) check("phv_valid_gate", phv_out_valid, phv_in_valid & ready_out);
            else               check("ready_without_pipe", ready_out, 1'b0);

            got_b = {m_tdata, m_tuser, m_tkeep, m_tlast};
            if (m_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", got_b, '0);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat_content", got_b, exp_b);
                end
                m_emitted++;
                if (pipe_ready_in) check("gate_closed_on_send", ready_out, 1'b0);
                if (m_inflight != 0) check("forced_send_err", drain_err, 1'b1);
            end else begin
                check("idle_bus_zero", got_b, '0);
            end
            if (m_err)    check("drain_err_model", drain_err, 1'b1);
            if (prev_err) check("drain_err_sticky", drain_err, 1'b1);
            check("drop_cnt_model", drop_cnt, m_drop);
            prev_err = drain_err;

            // In-flight bookkeeping from the rules: +1 per handshake, -1 per retire.
            hs = phv_in_valid & ready_out;
            if (hs && !phv_retire) begin
                if (m_inflight == 63) m_err = 1; else m_inflight++;
            end else if (phv_retire && !hs) begin
                if (m_inflight == 0) m_err = 1; else m_inflight--;
            end

            // Ingress: admit whole packets only if MAXB beats are free, truncate long ones.
            if (s_tvalid) begin
                if (!m_in_pkt) begin
                    m_idx  = 0;
                    m_keep = (DEPTH - (m_stored - m_emitted)) >= MAXB;
                    if (!m_keep && m_drop < 65535) m_drop++;
                end
                if (m_keep && m_idx < MAXB) begin
                    new_b = {s_tdata, s_tuser, s_tkeep, s_tlast | (m_idx == MAXB - 1)};
                    exp_q.push_back(new_b);
                    m_stored++;
                    m_idx++;
                end
                m_in_pkt = !s_tlast;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic send_pkt(input int nbeats, input logic [31:0] tag);
        for (int i = 0; i < nbeats; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = {448'h0, tag, 32'(i)};
            s_tuser  = {96'h0, tag ^ 32'hFFFF_0000};
            s_tkeep  = '1;
            s_tlast  = (i == nbeats - 1);
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_tvalid(input int budget);
        int n = 0;
        while (!m_tvalid && n < budget) begin
            tick();
            n++;
        end
        check("beat_wait_timeout", m_tvalid, 1'b1);
    endtask

    task automatic check_burst(input string name, input logic [31:0] tag, input int n);
        for (int j = 0; j < n; j++) begin
            check({name, "_valid"}, m_tvalid, 1'b1);
            check({name, "_data"}, m_tdata, {448'h0, tag, 32'(j)});
            check({name, "_last"}, m_tlast, (j == n - 1));
            tick();
        end
        check({name, "_after"}, m_tvalid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int beats;
        bit reopened;
        int extra;

        areset = 1'b1; phv_in = '0; phv_in_valid = 1'b0; pipe_ready_in = 1'b1; phv_retire = 1'b0;
        s_tdata = '0; s_tuser = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        tick(); tick();
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_drain_err", drain_err, 1'b0);
        check("rst_drop_cnt", drop_cnt, 16'h0);
        check("rst_gate_open", ready_out, 1'b1);
        areset = 1'b0;
        tick();

        // Idle pass-through with pipe_ready_in toggling: five handshakes.
        for (int i = 0; i < 10; i++) begin
            pipe_ready_in = (i % 2 == 0);
            phv_in_valid  = 1'b1;
            phv_in        = 32'h100 + 32'(i);
            #1;
            check("idle_ready_mirror", ready_out, (i % 2 == 0));
            check("idle_phv_data", phv_out, 32'h100 + 32'(i));
            tick();
        end
        phv_in_valid = 1'b0; pipe_ready_in = 1'b1;
        phv_retire = 1'b1; tick(); tick(); phv_retire = 1'b0;   // leaves 3 in flight

        // 1-beat packet with 3 in flight.
        send_pkt(1, 32'hB0);
        check("b_gate_open_t1", ready_out, 1'b1);
        tick();
        check("b_gate_closed_t2", ready_out, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_no_early_beat", m_tvalid, 1'b0);
        end
        phv_retire = 1'b1; tick(); tick(); tick(); phv_retire = 1'b0;
        check("b_d0_no_beat", m_tvalid, 1'b0);
        tick();
        check("b_d1_no_beat", m_tvalid, 1'b0);
        tick();
        check("b_d2_beat", m_tvalid, 1'b1);
        check("b_d2_data", m_tdata, {448'h0, 32'hB0, 32'h0});
        check("b_d2_last", m_tlast, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("b_settle_gate", ready_out, (i == 9));
        end

        // 4-beat packet: back-to-back, ordered, tlast on the last beat only.
        send_pkt(4, 32'hC0);
        wait_tvalid(40);
        check_burst("c_burst", 32'hC0, 4);
        repeat (12) tick();

        // Retires withheld: two PHVs stay in flight, DRAIN times out.
        phv_in_valid = 1'b1; phv_in = 32'hD00D; tick(); tick(); phv_in_valid = 1'b0;
        send_pkt(1, 32'hD0);
        for (int i = 1; i <= 19; i++) begin
            if (i == 17) check("d_err_before_timeout", drain_err, 1'b0);
            if (i == 18) check("d_err_after_timeout", drain_err, 1'b1);
            if (i == 19) check("d_forced_beat", m_tvalid, 1'b1);
            if (i < 19) tick();
        end
        repeat (12) tick();
        check("d_gate_reopened", ready_out, 1'b1);

        // Five 4-beat packets during DRAIN: the fifth is dropped.
        for (int p = 0; p < 5; p++) send_pkt(4, 32'hE0 + 32'(p));
        check("e_drop_cnt", drop_cnt, 16'd1);
        beats = 0; reopened = 0;
        for (int c = 0; c < 400 && beats < 16; c++) begin
            if (m_tvalid) beats++;
            if (ready_out) reopened = 1;
            tick();
        end
        check("e_beats_sent", beats, 16);
        check("e_no_reopen", reopened, 1'b0);
        repeat (12) tick();
        check("e_gate_reopened", ready_out, 1'b1);
        phv_retire = 1'b1; tick(); tick(); phv_retire = 1'b0;

        // Over-long packet: truncated to MAXB beats with forced tlast.
        send_pkt(5, 32'h60);
        wait_tvalid(40);
        check_burst("g_trunc", 32'h60, 4);
        repeat (12) tick();
        check("g_queue_drained", exp_q.size(), 0);

        // Reset during SEND beat 2 of 4.
        send_pkt(4, 32'hF0);
        wait_tvalid(40);
        tick();
        check("f_beat2_valid", m_tvalid, 1'b1);
        check("f_beat2_data", m_tdata, {448'h0, 32'hF0, 32'h1});
        areset = 1'b1;
        #1;
        check("f_async_clear", m_tvalid, 1'b0);
        tick();
        check("f_rst_tvalid", m_tvalid, 1'b0);
        check("f_rst_tdata", m_tdata, '0);
        check("f_rst_tlast", m_tlast, 1'b0);
        check("f_rst_drain_err", drain_err, 1'b0);
        check("f_rst_drop_cnt", drop_cnt, 16'h0);
        check("f_rst_gate", ready_out, 1'b1);
        areset = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_tvalid) extra++;
        end
        check("f_no_beats_after_rst", extra, 0);
        check("f_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
